// File: rtl/spu_issue_queue.sv
// In-order issue queue for special-unit ops (traps, CP0 moves, ERET, TLB, CACHE).
// The head entry issues only when it is the oldest instruction in the ROB.
package spu_iq_pkg;
    typedef logic [5:0] reg_addr_t;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] imm;
    } decoded_inst_t;

    typedef struct packed {
        decoded_inst_t inst;
        logic [31:0]   src1_value;
        logic [31:0]   src2_value;
        reg_addr_t     phy_dest;
        logic [3:0]    rob_entry_num;
    } issue_to_execute_bus_t;
endpackage

module spu_issue_queue
    import spu_iq_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int WB_PORTS = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       dispatch_valid,
    input  decoded_inst_t              dispatch_inst,
    input  reg_addr_t                  dispatch_src1_tag,
    input  reg_addr_t                  dispatch_src2_tag,
    input  logic                       dispatch_src1_ready,
    input  logic                       dispatch_src2_ready,
    input  reg_addr_t                  dispatch_phy_dest,
    input  logic [3:0]                 dispatch_rob_entry_num,
    output logic                       spu_iq_allowin,
    input  logic [WB_PORTS-1:0]        wakeup_valid,
    input  reg_addr_t [WB_PORTS-1:0]   wakeup_tag,
    input  logic [3:0]                 rob_head_num,
    input  logic                       spu_allowin,
    output reg_addr_t                  prf_raddr1,
    output reg_addr_t                  prf_raddr2,
    input  logic [31:0]                prf_rdata1,
    input  logic [31:0]                prf_rdata2,
    output logic                       issue_to_spu_valid,
    output issue_to_execute_bus_t      issue_inst
);
    localparam int IW = $clog2(DEPTH);

    typedef logic [IW:0] ptr_t;

    typedef struct packed {
        decoded_inst_t inst;
        reg_addr_t     src1_tag;
        reg_addr_t     src2_tag;
        logic          src1_rdy;
        logic          src2_rdy;
        reg_addr_t     phy_dest;
        logic [3:0]    rob_entry_num;
        logic          valid;
    } entry_t;

    entry_t          q [DEPTH];
    ptr_t            head;
    ptr_t            tail;
    logic [IW-1:0]   head_idx;
    logic [IW-1:0]   tail_idx;
    logic            empty;
    logic            full;
    logic            head_ready;
    logic            enq;
    entry_t          new_e;

    function automatic logic tag_hit(input reg_addr_t tag);
        logic hit;
        hit = 1'b0;
        for (int p = 0; p < WB_PORTS; p++) begin
            if (wakeup_valid[p] && wakeup_tag[p] == tag) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    assign head_idx = head[IW-1:0];
    assign tail_idx = tail[IW-1:0];
    assign empty    = (head == tail);
    assign full     = (head_idx == tail_idx) && (head[IW] != tail[IW]);

    assign spu_iq_allowin = !full;
    assign enq            = dispatch_valid && spu_iq_allowin && !flush;

    assign head_ready = !empty && q[head_idx].src1_rdy && q[head_idx].src2_rdy &&
                        (q[head_idx].rob_entry_num == rob_head_num);
    assign issue_to_spu_valid = head_ready && spu_allowin && !flush;

    // Popped and flushed slots are zeroed, so an empty queue presents all-zero head fields.
    assign prf_raddr1 = q[head_idx].src1_tag;
    assign prf_raddr2 = q[head_idx].src2_tag;

    always_comb begin
        issue_inst               = '0;
        issue_inst.inst          = q[head_idx].inst;
        issue_inst.src1_value    = prf_rdata1;
        issue_inst.src2_value    = prf_rdata2;
        issue_inst.phy_dest      = q[head_idx].phy_dest;
        issue_inst.rob_entry_num = q[head_idx].rob_entry_num;
    end

    // Writebacks in the dispatch cycle are folded in so the new entry never misses its wakeup.
    always_comb begin
        new_e               = '0;
        new_e.inst          = dispatch_inst;
        new_e.src1_tag      = dispatch_src1_tag;
        new_e.src2_tag      = dispatch_src2_tag;
        new_e.src1_rdy      = dispatch_src1_ready || tag_hit(dispatch_src1_tag);
        new_e.src2_rdy      = dispatch_src2_ready || tag_hit(dispatch_src2_tag);
        new_e.phy_dest      = dispatch_phy_dest;
        new_e.rob_entry_num = dispatch_rob_entry_num;
        new_e.valid         = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head <= '0;
            tail <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (q[i].valid) begin
                    if (tag_hit(q[i].src1_tag)) q[i].src1_rdy <= 1'b1;
                    if (tag_hit(q[i].src2_tag)) q[i].src2_rdy <= 1'b1;
                end
            end
            if (enq) begin
                q[tail_idx] <= new_e;
                tail        <= tail + ptr_t'(1);
            end
            // Enqueue and issue never target the same slot: that needs empty or full.
            if (issue_to_spu_valid) begin
                q[head_idx] <= '0;
                head        <= head + ptr_t'(1);
            end
        end
    end
endmodule

// File: tb/tb_spu_issue_queue.sv
// Bench for spu_issue_queue: directed vector table followed by random traffic
// checked against a queue-based model of the issue rules.
module tb_spu_issue_queue;
    import spu_iq_pkg::*;

    localparam int DEPTH = 4;
    localparam int WB    = 2;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  flush;
    logic                  dispatch_valid;
    decoded_inst_t         dispatch_inst;
    reg_addr_t             dispatch_src1_tag;
    reg_addr_t             dispatch_src2_tag;
    logic                  dispatch_src1_ready;
    logic                  dispatch_src2_ready;
    reg_addr_t             dispatch_phy_dest;
    logic [3:0]            dispatch_rob_entry_num;
    logic                  spu_iq_allowin;
    logic [WB-1:0]         wakeup_valid;
    reg_addr_t [WB-1:0]    wakeup_tag;
    logic [3:0]            rob_head_num;
    logic                  spu_allowin;
    reg_addr_t             prf_raddr1;
    reg_addr_t             prf_raddr2;
    logic [31:0]           prf_rdata1;
    logic [31:0]           prf_rdata2;
    logic                  issue_to_spu_valid;
    issue_to_execute_bus_t issue_inst;

    spu_issue_queue #(.DEPTH(DEPTH), .WB_PORTS(WB)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .flush                  (flush),
        .dispatch_valid         (dispatch_valid),
        .dispatch_inst          (dispatch_inst),
        .dispatch_src1_tag      (dispatch_src1_tag),
        .dispatch_src2_tag      (dispatch_src2_tag),
        .dispatch_src1_ready    (dispatch_src1_ready),
        .dispatch_src2_ready    (dispatch_src2_ready),
        .dispatch_phy_dest      (dispatch_phy_dest),
        .dispatch_rob_entry_num (dispatch_rob_entry_num),
        .spu_iq_allowin         (spu_iq_allowin),
        .wakeup_valid           (wakeup_valid),
        .wakeup_tag             (wakeup_tag),
        .rob_head_num           (rob_head_num),
        .spu_allowin            (spu_allowin),
        .prf_raddr1             (prf_raddr1),
        .prf_raddr2             (prf_raddr2),
        .prf_rdata1             (prf_rdata1),
        .prf_rdata2             (prf_rdata2),
        .issue_to_spu_valid     (issue_to_spu_valid),
        .issue_inst             (issue_inst)
    );

    always #5 clk = ~clk;

    // Register file stand-in: the data word encodes the address it was read from.
    function automatic logic [31:0] rd1(input reg_addr_t a);
        return 32'hA500_0000 | {26'd0, a};
    endfunction
    function automatic logic [31:0] rd2(input reg_addr_t a);
        return 32'h5A00_0000 | {26'd0, a};
    endfunction

    assign prf_rdata1 = rd1(prf_raddr1);
    assign prf_rdata2 = rd2(prf_raddr2);

    typedef struct {
        logic          rst;
        logic          fl;
        logic          dv;
        decoded_inst_t inst;
        reg_addr_t     t1;
        logic          r1;
        reg_addr_t     t2;
        logic          r2;
        reg_addr_t     dest;
        logic [3:0]    rob;
        logic [1:0]    wv;
        reg_addr_t     wt0;
        reg_addr_t     wt1;
        logic [3:0]    rh;
        logic          sa;
    } stim_t;

    typedef struct {
        stim_t      s;
        logic       allow;
        logic       valid;
        reg_addr_t  ra1;
        logic [3:0] rob;
    } vec_t;

    typedef struct {
        decoded_inst_t inst;
        reg_addr_t     t1;
        reg_addr_t     t2;
        bit            r1;
        bit            r2;
        reg_addr_t     dest;
        logic [3:0]    rob;
    } ment_t;

    int    vectors    = 0;
    int    miscompares = 0;
    stim_t cur;
    ment_t mq[$];
    vec_t  tbl[$];

    function automatic stim_t mk(int rst, int fl, int dv, int t1, int r1, int t2, int r2,
                                 int rob, int wv, int wt0, int wt1, int rh, int sa);
        stim_t s;
        s.rst  = 1'(rst);
        s.fl   = 1'(fl);
        s.dv   = 1'(dv);
        s.inst = '{opcode: 6'h10, rt: 5'(t1), rd: 5'd12, imm: 16'(rob)};
        s.t1   = reg_addr_t'(t1);
        s.r1   = 1'(r1);
        s.t2   = reg_addr_t'(t2);
        s.r2   = 1'(r2);
        s.dest = reg_addr_t'(rob + 32);
        s.rob  = 4'(rob);
        s.wv   = 2'(wv);
        s.wt0  = reg_addr_t'(wt0);
        s.wt1  = reg_addr_t'(wt1);
        s.rh   = 4'(rh);
        s.sa   = 1'(sa);
        return s;
    endfunction

    function automatic stim_t idle(int rh, int sa);
        return mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, rh, sa);
    endfunction

    function automatic stim_t disp(int rob, int t1, int r1, int rh);
        return mk(0, 0, 1, t1, r1, t1 + 1, 1, rob, 0, 0, 0, rh, 1);
    endfunction

    task automatic add(input stim_t s, input int allow, input int valid, input int ra1, input int rob);
        vec_t v;
        v.s     = s;
        v.allow = 1'(allow);
        v.valid = 1'(valid);
        v.ra1   = reg_addr_t'(ra1);
        v.rob   = 4'(rob);
        tbl.push_back(v);
    endtask

    task automatic compare(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input stim_t s);
        cur                    = s;
        reset                  = s.rst;
        flush                  = s.fl;
        dispatch_valid         = s.dv;
        dispatch_inst          = s.inst;
        dispatch_src1_tag      = s.t1;
        dispatch_src2_tag      = s.t2;
        dispatch_src1_ready    = s.r1;
        dispatch_src2_ready    = s.r2;
        dispatch_phy_dest      = s.dest;
        dispatch_rob_entry_num = s.rob;
        wakeup_valid           = s.wv;
        wakeup_tag[0]          = s.wt0;
        wakeup_tag[1]          = s.wt1;
        rob_head_num           = s.rh;
        spu_allowin            = s.sa;
    endtask

    function automatic bit hit(input reg_addr_t tag);
        return (cur.wv[0] && cur.wt0 == tag) || (cur.wv[1] && cur.wt1 == tag);
    endfunction

    function automatic bit m_valid();
        return mq.size() > 0 && mq[0].r1 && mq[0].r2 && mq[0].rob == cur.rh && cur.sa && !cur.fl;
    endfunction

    // The model advances one clock edge using the inputs held during the cycle.
    task automatic modelEdge();
        bit iss;
        bit en;
        if (cur.rst || cur.fl) begin
            mq.delete();
        end else begin
            iss = m_valid();
            en  = cur.dv && mq.size() < DEPTH;
            foreach (mq[i]) begin
                if (hit(mq[i].t1)) mq[i].r1 = 1'b1;
                if (hit(mq[i].t2)) mq[i].r2 = 1'b1;
            end
            if (iss) void'(mq.pop_front());
            if (en) mq.push_back('{cur.inst, cur.t1, cur.t2, cur.r1 || hit(cur.t1),
                                   cur.r2 || hit(cur.t2), cur.dest, cur.rob});
        end
    endtask

    task automatic checkOutput(input bit use_tbl, input vec_t v, input string name);
        issue_to_execute_bus_t e;
        reg_addr_t             ea1;
        reg_addr_t             ea2;
        if (use_tbl) begin
            compare({name, " allowin"}, 128'(spu_iq_allowin), 128'(v.allow));
            compare({name, " valid"}, 128'(issue_to_spu_valid), 128'(v.valid));
            compare({name, " raddr1"}, 128'(prf_raddr1), 128'(v.ra1));
            compare({name, " rob"}, 128'(issue_inst.rob_entry_num), 128'(v.rob));
            compare({name, " src1_value"}, 128'(issue_inst.src1_value), 128'(rd1(v.ra1)));
        end else begin
            e   = '0;
            ea1 = '0;
            ea2 = '0;
            if (mq.size() > 0) begin
                ea1             = mq[0].t1;
                ea2             = mq[0].t2;
                e.inst          = mq[0].inst;
                e.phy_dest      = mq[0].dest;
                e.rob_entry_num = mq[0].rob;
            end
            e.src1_value = rd1(ea1);
            e.src2_value = rd2(ea2);
            compare({name, " allowin"}, 128'(spu_iq_allowin), 128'(mq.size() < DEPTH));
            compare({name, " valid"}, 128'(issue_to_spu_valid), 128'(m_valid()));
            compare({name, " raddr1"}, 128'(prf_raddr1), 128'(ea1));
            compare({name, " raddr2"}, 128'(prf_raddr2), 128'(ea2));
            compare({name, " bus"}, 128'(issue_inst), 128'(e));
        end
    endtask

    task automatic step(input stim_t s, input bit use_tbl, input vec_t v, input string name);
        applyStimulus(s);
        @(negedge clk);
        checkOutput(use_tbl, v, name);
        modelEdge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t  dummy;
        stim_t s;

        // In-order drain of four CP0 reads, full-with-pop, and spu back-pressure.
        add(idle(0, 1), 1, 0, 0, 0);
        add(disp(3, 20, 1, 2), 1, 0, 0, 0);
        add(disp(4, 21, 1, 2), 1, 0, 20, 3);
        add(disp(5, 22, 1, 2), 1, 0, 20, 3);
        add(disp(6, 23, 1, 2), 1, 0, 20, 3);
        add(idle(2, 1), 0, 0, 20, 3);
        add(disp(7, 24, 1, 3), 0, 1, 20, 3);
        add(disp(7, 24, 1, 3), 1, 0, 21, 4);
        add(idle(4, 1), 0, 1, 21, 4);
        add(idle(4, 1), 1, 0, 22, 5);
        add(idle(5, 1), 1, 1, 22, 5);
        add(idle(5, 1), 1, 0, 23, 6);
        add(idle(6, 1), 1, 1, 23, 6);
        add(idle(6, 1), 1, 0, 24, 7);
        add(idle(7, 0), 1, 0, 24, 7);
        add(idle(7, 0), 1, 0, 24, 7);
        add(idle(7, 0), 1, 0, 24, 7);
        add(idle(7, 1), 1, 1, 24, 7);
        add(idle(7, 1), 1, 0, 0, 0);
        // Trap waiting on tag 9, woken by port 1; no same-cycle wakeup-to-issue.
        add(disp(8, 9, 0, 8), 1, 0, 0, 0);
        add(idle(8, 1), 1, 0, 9, 8);
        add(mk(0, 0, 0, 0, 1, 0, 1, 0, 2, 0, 9, 8, 1), 1, 0, 9, 8);
        add(idle(8, 1), 1, 1, 9, 8);
        // Enqueue bypass: src2 tag 12 broadcast in the dispatch cycle.
        add(mk(0, 0, 1, 10, 1, 12, 0, 9, 1, 12, 0, 9, 1), 1, 0, 0, 0);
        add(idle(9, 1), 1, 1, 10, 9);
        // Three entries past the pointer wrap, then flush with a ready head.
        add(disp(10, 40, 1, 15), 1, 0, 0, 0);
        add(disp(11, 41, 1, 15), 1, 0, 40, 10);
        add(disp(12, 42, 1, 15), 1, 0, 40, 10);
        add(mk(0, 1, 1, 43, 1, 44, 1, 13, 0, 0, 0, 10, 1), 1, 0, 40, 10);
        add(disp(13, 43, 1, 13), 1, 0, 0, 0);
        add(idle(13, 1), 1, 1, 43, 13);
        // Reset with one entry pending.
        add(disp(14, 44, 1, 0), 1, 0, 0, 0);
        add(mk(1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1), 1, 0, 44, 14);
        add(idle(0, 1), 1, 0, 0, 0);

        applyStimulus(mk(1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1));
        repeat (2) @(posedge clk);
        #1;
        mq.delete();

        dummy = tbl[0];
        foreach (tbl[i]) begin
            step(tbl[i].s, 1'b1, tbl[i], $sformatf("row%0d", i));
        end

        for (int n = 0; n < 3000; n++) begin
            s.rst  = ($urandom_range(0, 199) == 0);
            s.fl   = ($urandom_range(0, 29) == 0);
            s.dv   = 1'($urandom_range(0, 1));
            s.inst = decoded_inst_t'($urandom);
            s.t1   = reg_addr_t'($urandom_range(0, 15));
            s.t2   = reg_addr_t'($urandom_range(0, 15));
            s.r1   = ($urandom_range(0, 3) != 0);
            s.r2   = ($urandom_range(0, 3) != 0);
            s.dest = reg_addr_t'($urandom_range(0, 63));
            s.rob  = 4'($urandom_range(0, 15));
            s.wv   = 2'($urandom_range(0, 3));
            s.wt0  = reg_addr_t'($urandom_range(0, 15));
            s.wt1  = reg_addr_t'($urandom_range(0, 15));
            if (mq.size() > 0 && $urandom_range(0, 3) != 0) s.rh = mq[0].rob;
            else s.rh = 4'($urandom_range(0, 15));
            s.sa   = ($urandom_range(0, 3) != 0);
            step(s, 1'b0, dummy, $sformatf("rand%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
